// File: rtl/antiglitch_bank.sv
// -----------------------------------------------------------------------------
// antiglitch_bank
//   Bank of CH independent glitch filters. Each channel has an optional
//   synchroniser, a saturating up/down integrator and a hysteresis comparator.
//   The comparator drives a registered clean level and one-cycle rise/fall
//   pulses.
//
// Parameters
//   CH     number of channels (1..32)
//   M      integrator saturation ceiling (>= 1)
//   TH_HI  count at or above which clean goes high
//   TH_LO  count at or below which clean goes low (TH_LO < TH_HI <= M)
//   SYNC   synchroniser depth 0..3 (0 = input used directly)
//   INIT   reset level of outputs and integrators (0 or 1)
//
// Ports
//   clk     clock, all state updates on its rising edge
//   rst     synchronous active-high reset
//   en      integrate enable, common to all channels
//   glitch  raw noisy inputs, bit i = channel i
//   clean   filtered registered level per channel
//   rise    one-cycle pulse after each clean 0->1 transition
//   fall    one-cycle pulse after each clean 1->0 transition
// -----------------------------------------------------------------------------
module antiglitch_bank #(
  parameter int CH    = 4,
  parameter int M     = 16,
  parameter int TH_HI = 12,
  parameter int TH_LO = 4,
  parameter int SYNC  = 2,
  parameter int INIT  = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [CH-1:0] glitch,
  output logic [CH-1:0] clean,
  output logic [CH-1:0] rise,
  output logic [CH-1:0] fall
);

  localparam int CW = $clog2(M + 1);
  localparam logic [CW-1:0] M_C     = CW'(M);
  localparam logic [CW-1:0] TH_HI_C = CW'(TH_HI);
  localparam logic [CW-1:0] TH_LO_C = CW'(TH_LO);
  localparam logic          INIT_B  = (INIT != 0);
  // Integrator reset value sits on the rail matching the reset output level,
  // so clean and cnt are consistent straight out of reset.
  localparam logic [CW-1:0] CNT_RST = INIT_B ? M_C : '0;

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      logic          s;
      logic [CW-1:0] cnt_reg;
      logic [CW-1:0] cnt_next;
      logic          clean_reg;
      logic          clean_next;
      logic          rise_reg;
      logic          fall_reg;

      if (SYNC == 0) begin : g_nosync
        assign s = glitch[gi];
      end else begin : g_sync
        logic [SYNC-1:0] sync_reg;
        // Shift register: bit 0 samples the raw input, MSB feeds the integrator.
        // The chain keeps shifting regardless of en.
        always_ff @(posedge clk) begin
          if (rst) begin
            sync_reg <= {SYNC{INIT_B}};
          end else begin
            sync_reg <= (sync_reg << 1) | SYNC'(glitch[gi]);
          end
        end
        assign s = sync_reg[SYNC-1];
      end

      // Saturating integrator plus hysteresis decision on the *next* count so
      // that clean moves on the same edge the count crosses a threshold.
      always_comb begin
        cnt_next   = cnt_reg;
        clean_next = clean_reg;
        if (en) begin
          if (s && (cnt_reg != M_C)) begin
            cnt_next = cnt_reg + CW'(1);
          end else if (!s && (cnt_reg != '0)) begin
            cnt_next = cnt_reg - CW'(1);
          end
          if (cnt_next >= TH_HI_C) begin
            clean_next = 1'b1;
          end else if (cnt_next <= TH_LO_C) begin
            clean_next = 1'b0;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg   <= CNT_RST;
          clean_reg <= INIT_B;
          rise_reg  <= 1'b0;
          fall_reg  <= 1'b0;
        end else begin
          cnt_reg   <= cnt_next;
          clean_reg <= clean_next;
          rise_reg  <= clean_next & ~clean_reg;
          fall_reg  <= ~clean_next & clean_reg;
        end
      end

      assign clean[gi] = clean_reg;
      assign rise[gi]  = rise_reg;
      assign fall[gi]  = fall_reg;
    end
  endgenerate

endmodule

// File: tb/tb_antiglitch_bank.sv
// -----------------------------------------------------------------------------
// tb_antiglitch_bank
//   Two instances (INIT=0 and INIT=1) share one stimulus stream. A behavioural
//   model tracks sampled-input history, integer counts and hysteresis state for
//   both; a negedge process compares every cycle. Directed phases pin edge
//   counts with literal expectations, then a randomized phase runs.
// -----------------------------------------------------------------------------
module tb_antiglitch_bank;
  localparam int CH = 2, M = 16, TH_HI = 12, TH_LO = 4, SYNC = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic [CH-1:0] glitch = '0;
  logic [CH-1:0] clean0, rise0, fall0;
  logic [CH-1:0] clean1, rise1, fall1;

  int n_checks = 0;
  int n_fails  = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  antiglitch_bank #(.CH(CH), .M(M), .TH_HI(TH_HI), .TH_LO(TH_LO), .SYNC(SYNC), .INIT(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .glitch(glitch),
    .clean(clean0), .rise(rise0), .fall(fall0));

  antiglitch_bank #(.CH(CH), .M(M), .TH_HI(TH_HI), .TH_LO(TH_LO), .SYNC(SYNC), .INIT(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .glitch(glitch),
    .clean(clean1), .rise(rise1), .fall(fall1));

  // ---------------- behavioural model, index [instance][channel] -------------
  int m_hist  [2][CH][SYNC];   // hist[..][0] = most recently sampled input
  int m_cnt   [2][CH];
  bit m_clean [2][CH];
  bit m_rise  [2][CH];
  bit m_fall  [2][CH];

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < CH; c++) begin
        if (rst) begin
          for (int d = 0; d < SYNC; d++) m_hist[k][c][d] = k;
          m_cnt[k][c]   = (k == 1) ? M : 0;
          m_clean[k][c] = (k == 1);
          m_rise[k][c]  = 0;
          m_fall[k][c]  = 0;
        end else begin
          int s;
          bit nc;
          s = m_hist[k][c][SYNC-1];
          for (int d = SYNC-1; d > 0; d--) m_hist[k][c][d] = m_hist[k][c][d-1];
          m_hist[k][c][0] = int'(glitch[c]);
          m_rise[k][c] = 0;
          m_fall[k][c] = 0;
          if (en) begin
            if (s == 1) m_cnt[k][c] = (m_cnt[k][c] + 1 > M) ? M : m_cnt[k][c] + 1;
            else        m_cnt[k][c] = (m_cnt[k][c] - 1 < 0) ? 0 : m_cnt[k][c] - 1;
            nc = m_clean[k][c];
            if (m_cnt[k][c] >= TH_HI) nc = 1;
            else if (m_cnt[k][c] <= TH_LO) nc = 0;
            m_rise[k][c]  = nc && !m_clean[k][c];
            m_fall[k][c]  = !nc && m_clean[k][c];
            m_clean[k][c] = nc;
          end
        end
      end
    end
  endtask

  function automatic logic [CH-1:0] pack(input int k, input int which);
    logic [CH-1:0] v;
    v = '0;
    for (int c = 0; c < CH; c++)
      v[c] = (which == 0) ? m_clean[k][c] : (which == 1) ? m_rise[k][c] : m_fall[k][c];
    return v;
  endfunction

  task automatic check(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("clean0", clean0, pack(0, 0));
      check("rise0",  rise0,  pack(0, 1));
      check("fall0",  fall0,  pack(0, 2));
      check("clean1", clean1, pack(1, 0));
      check("rise1",  rise1,  pack(1, 1));
      check("fall1",  fall1,  pack(1, 2));
      check("rise_and_fall0", rise0 & fall0, '0);
    end
  end

  // Drive inputs at negedge, take one rising edge, update model, settle.
  task automatic step(input logic r, input logic e, input logic [CH-1:0] g);
    @(negedge clk);
    rst = r; en = e; glitch = g;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  int rise_cnt;
  logic [CH-1:0] lvl;

  initial begin
    // Reset
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 2'b00);
    chk_en = 1'b1;
    check("reset_clean0", clean0, 2'b00);
    check("reset_clean1", clean1, 2'b11);
    check("reset_pulses", rise0 | fall0 | rise1 | fall1, 2'b00);

    // Rising step on channel 0: clean rises on edge 14
    for (int e = 1; e <= 20; e++) begin
      step(1'b0, 1'b1, 2'b01);
      if (e == 13) check("rise_edge13_clean", clean0, 2'b00);
      if (e == 14) begin
        check("rise_edge14_clean", clean0, 2'b01);
        check("rise_edge14_pulse", rise0, 2'b01);
      end
      if (e == 15) check("rise_edge15_pulse", rise0, 2'b00);
    end

    // Falling step from saturation: clean falls on edge 14
    for (int e = 1; e <= 20; e++) begin
      step(1'b0, 1'b1, 2'b00);
      if (e == 13) check("fall_edge13_clean", clean0, 2'b01);
      if (e == 14) begin
        check("fall_edge14_clean", clean0, 2'b00);
        check("fall_edge14_pulse", fall0, 2'b01);
      end
      if (e == 15) check("fall_edge15_pulse", fall0, 2'b00);
    end

    // Alternating input never reaches a threshold
    rise_cnt = 0;
    for (int e = 0; e < 40; e++) begin
      step(1'b0, 1'b1, (e % 2 == 0) ? 2'b01 : 2'b00);
      if (rise0[0]) rise_cnt++;
    end
    check("alt_no_rise", CH'(rise_cnt), '0);
    check("alt_clean", clean0, 2'b00);

    // Hysteresis band: ramp to 8 (edges 3..10), then 3 x 0 and 3 x 1
    for (int e = 0; e < 6; e++) step(1'b0, 1'b1, 2'b00);   // drain to 0
    for (int e = 0; e < 10; e++) step(1'b0, 1'b1, 2'b01);
    for (int e = 0; e < 3; e++)  step(1'b0, 1'b1, 2'b00);
    for (int e = 0; e < 3; e++)  step(1'b0, 1'b1, 2'b01);
    check("hyst_hold_low", clean0, 2'b00);

    // Enable freeze: restart from reset, 8 enabled edges -> cnt 6,
    // 10 disabled edges, then 6 more enabled edges to reach 12.
    step(1'b1, 1'b1, 2'b00);
    for (int e = 0; e < 8; e++)  step(1'b0, 1'b1, 2'b01);
    for (int e = 0; e < 10; e++) step(1'b0, 1'b0, 2'b01);
    check("freeze_clean", clean0, 2'b00);
    for (int e = 1; e <= 6; e++) begin
      step(1'b0, 1'b1, 2'b01);
      if (e == 5) check("resume_edge5_clean", clean0, 2'b00);
      if (e == 6) check("resume_edge6_rise", rise0, 2'b01);
    end

    // Reset mid-operation: ch1 saturated high, ch0 at an intermediate count
    for (int e = 0; e < 20; e++) step(1'b0, 1'b1, 2'b11);
    for (int e = 0; e < 8; e++)  step(1'b0, 1'b1, 2'b10);
    step(1'b1, 1'b1, 2'b10);
    check("midrst_clean0", clean0, 2'b00);
    check("midrst_fall0",  fall0,  2'b00);
    check("midrst_clean1", clean1, 2'b11);
    check("midrst_rise1",  rise1,  2'b00);

    // Randomized phase: slowly wandering levels with noise, occasional reset/en=0
    lvl = '0;
    for (int e = 0; e < 4000; e++) begin
      logic [CH-1:0] g;
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 24) == 0) lvl[c] = ~lvl[c];
        g[c] = ($urandom_range(0, 6) == 0) ? ~lvl[c] : lvl[c];
      end
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) != 0), g);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/antiglitch_bank.md
ANTIGLITCH_BANK -- requirements
Module: antiglitch_bank

Interface
REQ-001 Parameter CH, default 4: number of independent input channels, 1..32.
REQ-002 Parameter M, default 16: integrator saturation ceiling, M >= 1.
REQ-003 Parameter TH_HI, default 12: count at or above which a channel's output goes high.
REQ-004 Parameter TH_LO, default 4: count at or below which a channel's output goes low; 0 <= TH_LO < TH_HI <= M.
REQ-005 Parameter SYNC, default 2: input synchroniser depth, 0..3; 0 means no synchroniser.
REQ-006 Parameter INIT, default 0: reset level of outputs and integrators, 0 or 1.
REQ-007 clk  input  1  single clock; all state updates on its rising edge.
REQ-008 rst  input  1  reset, synchronous, active-high.
REQ-009 en  input  1  integrate enable, common to all channels.
REQ-010 glitch  input  CH  raw, possibly asynchronous, noisy inputs; bit i is channel i.
REQ-011 clean  output  CH  filtered, registered level per channel.
REQ-012 rise  output  CH  one-cycle pulse on each clean 0->1 transition.
REQ-013 fall  output  CH  one-cycle pulse on each clean 1->0 transition.

Function
REQ-014 Each channel passes glitch[i] through a SYNC-deep flip-flop chain; output s[i]; SYNC=0 uses glitch[i] directly.
REQ-015 Each channel holds an unsigned integrator cnt[i], width $clog2(M+1).
REQ-016 When en=1: s[i]=1 and cnt[i]<M -> cnt[i]+1; s[i]=0 and cnt[i]>0 -> cnt[i]-1; otherwise hold (saturate at 0 and at M, no wrap).
REQ-017 When en=0: cnt, clean hold; rise, fall are 0; the synchroniser chain keeps shifting.
REQ-018 Next clean[i] is computed from next cnt[i]: 1 if >= TH_HI, 0 if <= TH_LO, else hold current value (hysteresis).
REQ-019 clean[i] updates on the same edge as the cnt[i] update that crosses a threshold; no extra register stage.
REQ-020 rise[i]/fall[i] are registered, asserted for exactly the one cycle following the edge on which clean[i] changes, never both at once.
REQ-021 Latency: from a steady step on glitch[i] with cnt at the opposite rail, clean[i] changes on the (SYNC + TH_HI)th edge for a rising step from 0, and the (SYNC + M - TH_LO)th edge for a falling step from M, counting the first edge that samples the new level as edge 1.
REQ-022 A single-cycle pulse of either polarity never toggles clean when cnt is at a rail and TH_HI - TH_LO >= 2.
REQ-023 Channels are fully independent; simultaneous events on several channels are each processed in the same cycle.

Reset
REQ-024 rst=1 at a rising edge: synchroniser flops = INIT, cnt = (INIT ? M : 0), clean = {CH{INIT}}, rise = 0, fall = 0.
REQ-025 Reset dominates en and glitch; asserted mid-operation it overrides any in-progress count on that same edge, with no rise/fall pulse generated by reset.
REQ-026 First integration occurs on the first edge with rst=0 and en=1; synchroniser contents after reset equal INIT, so no spurious count.

Verification (CH=2, M=16, TH_HI=12, TH_LO=4, SYNC=2, INIT=0)
REQ-027 Reset, en=1, glitch[0] held 1 -> clean[0] rises on edge 14, rise[0]=1 for one cycle after it; clean[1] stays 0, cnt[0] saturates at 16.
REQ-028 From cnt[0]=16, glitch[0] held 0 -> clean[0] falls on edge 14 (cnt reaches 4), fall[0] one-cycle pulse; cnt saturates at 0.
REQ-029 From clean[0]=0, alternating pattern 1,0,1,0,... for 40 cycles -> cnt[0] oscillates between 0 and 1, clean[0], rise[0] stay 0.
REQ-030 Ramp cnt[0] to 8 with clean[0]=0, then 3 cycles of 0 and 3 of 1 -> clean[0] holds 0 (hysteresis band); repeat from clean[0]=1 -> holds 1.
REQ-031 en=0 for 10 cycles mid-ramp with glitch=1 -> cnt, clean frozen, no pulses; resumes from frozen count when en=1.
REQ-032 rst pulsed for one cycle while cnt[0]=10, glitch[1] held 1 with cnt[1]=16 -> next cycle cnt=0, clean=00, no fall pulse; with INIT=1 -> cnt=16, clean=11, no rise pulse.
